// File: rtl/umi_arb_pkg.sv
// Shared types and helpers for the UMI request arbiter.
// The watchdog is built only when UMI_ARB_TIMEOUT_EN is defined.
package umi_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEF = 255;
    localparam int ARB_MAX_N       = 16;

    // First set bit of valid at or above ptr, wrapping at n.
    function automatic logic [ARB_MAX_N-1:0] rr_pick(
        input logic [ARB_MAX_N-1:0] valid,
        input logic [3:0]           ptr,
        input int                   n
    );
        logic [ARB_MAX_N-1:0] s;
        logic                 hit;
        int                   idx;
        s   = '0;
        hit = 1'b0;
        for (int k = 0; k < ARB_MAX_N; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !hit && valid[idx[3:0]]) begin
                s[idx[3:0]] = 1'b1;
                hit         = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/umi_arb_rr.sv
// Combinational round-robin / fixed-priority picker, one-hot result.
// Fixed priority is a round-robin search that always starts at port 0.
module umi_arb_rr
    import umi_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 mode_i,
    output logic [N-1:0]         sel_o
);

    logic [ARB_MAX_N-1:0] valid_ext;
    logic [ARB_MAX_N-1:0] pick_full;
    logic                 unused_pick;

    always_comb begin
        valid_ext          = '0;
        valid_ext[N-1:0]   = valid_i;
        pick_full = rr_pick(valid_ext, mode_i ? 4'd0 : 4'(ptr_i), N);
    end

    assign sel_o       = pick_full[N-1:0];
    assign unused_pick = |(pick_full >> N);

endmodule

// File: rtl/umi_req_arbiter.sv
// N-to-1 UMI request arbiter with lock-until-EOM and registered output.
// Define UMI_ARB_TIMEOUT_EN to add the lock watchdog (TIMEOUT parameter).
module umi_req_arbiter
    import umi_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 128,
    parameter int EOMBIT = 22
`ifdef UMI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 arb_mode,
    input  logic [N-1:0]         umi_in_valid,
    input  logic [N*CW-1:0]      umi_in_cmd,
    input  logic [N*AW-1:0]      umi_in_dstaddr,
    input  logic [N*AW-1:0]      umi_in_srcaddr,
    input  logic [N*DW-1:0]      umi_in_data,
    output logic [N-1:0]         umi_in_ready,
    output logic                 umi_out_valid,
    output logic [CW-1:0]        umi_out_cmd,
    output logic [AW-1:0]        umi_out_dstaddr,
    output logic [AW-1:0]        umi_out_srcaddr,
    output logic [DW-1:0]        umi_out_data,
    input  logic                 umi_out_ready,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 lock_timeout
);

    localparam int IW = $clog2(N);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q;
    logic          out_valid_q;
    logic [CW-1:0] cmd_q;
    logic [AW-1:0] dst_q, src_q;
    logic [DW-1:0] data_q;

    logic [N-1:0]  pick, sel;
    logic [IW-1:0] xid;
    logic [CW-1:0] xcmd;
    logic [AW-1:0] xdst, xsrc;
    logic [DW-1:0] xdata;
    logic          load_en, xfer, eom;

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
        return (id == IW'(N - 1)) ? '0 : id + 1'b1;
    endfunction

    umi_arb_rr #(.N(N)) u_rr (
        .valid_i (umi_in_valid),
        .ptr_i   (rr_ptr_q),
        .mode_i  (arb_mode),
        .sel_o   (pick)
    );

    assign load_en = !out_valid_q || umi_out_ready;

    always_comb begin
        sel = pick;
        if (state_q == LOCKED) begin
            sel          = '0;
            sel[owner_q] = 1'b1;
        end
        xid   = '0;
        xcmd  = '0;
        xdst  = '0;
        xsrc  = '0;
        xdata = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                xid   = IW'(i);
                xcmd  = umi_in_cmd[i*CW +: CW];
                xdst  = umi_in_dstaddr[i*AW +: AW];
                xsrc  = umi_in_srcaddr[i*AW +: AW];
                xdata = umi_in_data[i*DW +: DW];
            end
        end
    end

    assign umi_in_ready = load_en ? sel : '0;
    assign xfer         = |(umi_in_valid & umi_in_ready);
    assign eom          = xcmd[EOMBIT];

`ifdef UMI_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
`ifdef UMI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef UMI_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (xfer) begin
                    if (eom) begin
                        rr_ptr_d = next_id(xid);
                    end else begin
                        state_d = LOCKED;
                        owner_d = xid;
                    end
                end
            end
            LOCKED: begin
                if (xfer) begin
`ifdef UMI_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    if (eom) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id(owner_q);
                    end
                end
`ifdef UMI_ARB_TIMEOUT_EN
                else if (!umi_in_valid[owner_q]) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TIMEOUT)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id(owner_q);
                        to_d     = 1'b1;
                        cnt_d    = '0;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            cmd_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            if (load_en) begin
                out_valid_q <= xfer;
                if (xfer) begin
                    grant_q <= xid;
                    cmd_q   <= xcmd;
                    dst_q   <= xdst;
                    src_q   <= xsrc;
                    data_q  <= xdata;
                end
            end
        end
    end

`ifdef UMI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign lock_timeout = to_q;
`else
    assign lock_timeout = 1'b0;
`endif

    assign umi_out_valid   = out_valid_q;
    assign umi_out_cmd     = cmd_q;
    assign umi_out_dstaddr = dst_q;
    assign umi_out_srcaddr = src_q;
    assign umi_out_data    = data_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Randomized scoreboard bench for umi_req_arbiter.
// Reference model tracks lock owner, rr pointer and output occupancy.
module tb_umi_req_arbiter;

    localparam int N      = 4;
    localparam int CW     = 32;
    localparam int AW     = 64;
    localparam int DW     = 128;
    localparam int EOMBIT = 22;
    localparam int TMO    = 4;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            arb_mode = 1'b0;
    logic [N-1:0]    umi_in_valid = '0;
    logic [N*CW-1:0] umi_in_cmd = '0;
    logic [N*AW-1:0] umi_in_dstaddr = '0;
    logic [N*AW-1:0] umi_in_srcaddr = '0;
    logic [N*DW-1:0] umi_in_data = '0;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [CW-1:0]   umi_out_cmd;
    logic [AW-1:0]   umi_out_dstaddr;
    logic [AW-1:0]   umi_out_srcaddr;
    logic [DW-1:0]   umi_out_data;
    logic            umi_out_ready = 1'b1;
    logic [1:0]      grant_id;
    logic            lock_timeout;

    umi_req_arbiter #(
        .N(N), .CW(CW), .AW(AW), .DW(DW), .EOMBIT(EOMBIT)
`ifdef UMI_ARB_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .arb_mode        (arb_mode),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready),
        .grant_id        (grant_id),
        .lock_timeout    (lock_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } pkt_t;

    pkt_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated on the falling edge, state applies at the next rising edge.
    bit           m_locked, m_full, m_to, ld;
    int           m_owner, m_ptr, m_cnt, xid, j;
    logic [N-1:0] exp_sel, exp_rdy;
    pkt_t         p;

    always @(negedge clk) begin
        if (!nreset) begin
            m_locked = 0; m_ptr = 0; m_owner = 0;
            m_full = 0; m_to = 0; m_cnt = 0;
            sbq.delete();
        end else begin
            exp_sel = '0;
            if (m_locked) begin
                exp_sel[m_owner] = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = arb_mode ? k : (m_ptr + k) % N;
                    if (umi_in_valid[j]) begin
                        exp_sel[j] = 1'b1;
                        break;
                    end
                end
            end
            ld      = !m_full || umi_out_ready;
            exp_rdy = ld ? exp_sel : '0;
            chk("in_ready", 64'(umi_in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(umi_out_valid), 64'(m_full));
            chk("lock_timeout", 64'(lock_timeout), 64'(m_to));
            m_to = 0;
            xid  = -1;
            for (int i = 0; i < N; i++)
                if (exp_rdy[i] && umi_in_valid[i]) xid = i;
            if (xid >= 0) begin
                p.id   = xid;
                p.cmd  = umi_in_cmd[xid*CW +: CW];
                p.dst  = umi_in_dstaddr[xid*AW +: AW];
                p.src  = umi_in_srcaddr[xid*AW +: AW];
                p.data = umi_in_data[xid*DW +: DW];
                sbq.push_back(p);
                m_cnt = 0;
                if (p.cmd[EOMBIT]) begin
                    m_locked = 0;
                    m_ptr    = (xid + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner  = xid;
                end
            end
`ifdef UMI_ARB_TIMEOUT_EN
            else if (m_locked && !umi_in_valid[m_owner]) begin
                m_cnt++;
                if (m_cnt == TMO) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % N;
                    m_to     = 1;
                    m_cnt    = 0;
                end
            end
`endif
            if (ld) m_full = (xid >= 0);
        end
    end

    // Monitor: every packet accepted downstream must match the oldest expected one.
    pkt_t q;
    always @(negedge clk) begin
        if (nreset && umi_out_valid && umi_out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL pkt unexpected id %0d data %h", grant_id, umi_out_data);
            end else begin
                q = sbq.pop_front();
                if (int'(grant_id) != q.id || umi_out_cmd !== q.cmd ||
                    umi_out_dstaddr !== q.dst || umi_out_srcaddr !== q.src ||
                    umi_out_data !== q.data) begin
                    errors++;
                    $display("FAIL pkt got id %0d data %h want id %0d data %h",
                             grant_id, umi_out_data, q.id, q.data);
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] eom,
                       input logic rdy);
        logic [CW-1:0] c;
        @(posedge clk);
        #1;
        umi_in_valid  = v;
        umi_out_ready = rdy;
        for (int i = 0; i < N; i++) begin
            c = CW'($urandom);
            c[EOMBIT] = eom[i];
            umi_in_cmd[i*CW +: CW]     = c;
            umi_in_dstaddr[i*AW +: AW] = {$urandom, $urandom};
            umi_in_srcaddr[i*AW +: AW] = {$urandom, $urandom};
            umi_in_data[i*DW +: DW]    = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk("rst out_valid", 64'(umi_out_valid), 64'd0);
        chk("rst grant_id", 64'(grant_id), 64'd0);
        chk("rst lock_timeout", 64'(lock_timeout), 64'd0);
        chk("rst in_ready", 64'(umi_in_ready & {N{umi_out_valid}}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    int k;

    initial begin
        #2;
        chk("init out_valid", 64'(umi_out_valid), 64'd0);
        do_reset();

        // All ports busy with single-packet messages
        repeat (12) cyc('1, '1, 1'b1);

        // Port 2 three-packet message while port 0 waits
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b0101, 4'b0001, 1'b1);
        cyc(4'b0101, 4'b0101, 1'b1);
        repeat (2) cyc(4'b0001, 4'b0001, 1'b1);

        // Fixed priority starves port 3
        arb_mode = 1'b1;
        repeat (10) cyc(4'b1010, 4'($urandom), 1'b1);
        cyc(4'b1010, 4'b1111, 1'b1);
        arb_mode = 1'b0;

        // Port 0 streams 0..7 under alternating backpressure
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            cyc(4'b0001, 4'b0001, (c % 2) == 0);
            umi_in_data[0 +: DW] = DW'(k);
            @(negedge clk);
            if (umi_in_ready[0]) k++;
        end
        chk("stream words", 64'(k), 64'd8);
        repeat (3) cyc('0, '0, 1'b1);

        // Reset while port 3 holds the lock
        cyc(4'b1000, 4'b0000, 1'b1);
        cyc(4'b1000, 4'b0000, 1'b1);
        do_reset();
        repeat (6) cyc('1, '1, 1'b1);

`ifdef UMI_ARB_TIMEOUT_EN
        cyc(4'b0010, 4'b0000, 1'b1);
        repeat (8) cyc(4'b0100, 4'b0100, 1'b1);
`endif

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) arb_mode = 1'($urandom);
            cyc(4'($urandom), 4'($urandom), ($urandom % 4) != 0);
        end

        // Drain so every lock closes and the queue empties
        arb_mode = 1'b0;
        repeat (4) cyc('1, '1, 1'b1);
        repeat (4) cyc('0, '0, 1'b1);
        @(negedge clk);
        chk("queue empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/umi_req_arbiter.md
Name: umi_req_arbiter

Overview:
- N-to-1 UMI request arbiter that lets several hosts share one UMI device port, such as a umi_fifo feeding a umi_mem_agent.
- Grant is round-robin (or fixed priority, selectable at runtime) and is held across multi-packet transactions until the end-of-message (EOM) packet is accepted.
- The output is registered, giving 1-cycle latency and full throughput of one packet per cycle.

Parameters:
- N, 4, number of requester ports (2..16)
- CW, 32, UMI command width
- AW, 64, UMI address width
- DW, 128, UMI data width
- EOMBIT, 22, bit position of EOM inside cmd

Ports:
- clk  input  1  clock
- nreset  input  1  async active-low reset
- arb_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- umi_in_valid  input  N  per-port valid
- umi_in_cmd  input  N*CW  packed cmd, port i at [i*CW +: CW]
- umi_in_dstaddr  input  N*AW  packed
- umi_in_srcaddr  input  N*AW  packed
- umi_in_data  input  N*DW  packed
- umi_in_ready  output  N  per-port ready
- umi_out_valid  output  1  registered valid
- umi_out_cmd  output  CW  registered
- umi_out_dstaddr  output  AW  registered
- umi_out_srcaddr  output  AW  registered
- umi_out_data  output  DW  registered
- umi_out_ready  input  1  downstream ready
- grant_id  output  $clog2(N)  index of the port that sourced the current out packet
- lock_timeout  output  1  1-cycle pulse on lock release by watchdog (0 without macro)

Behaviour:
- Interface: one clock, clk; reset nreset is asynchronous, active-low.
- Reset values: umi_out_valid=0; all out fields, grant_id, lock_timeout=0; state=IDLE; rr_ptr=0.
- load_en = !umi_out_valid | umi_out_ready. This is a pipelined register with no bubble.
- umi_in_ready[i] = load_en & sel[i]. Ready may depend combinationally on valid; at most one bit is set.
- A transfer on port i occurs when umi_in_valid[i] & umi_in_ready[i]. The out register loads that port's fields and sets grant_id=i.
- If load_en is true and no port transfers, umi_out_valid clears.
- IDLE state selection:
  - arb_mode=0: the first valid port searching from rr_ptr upward, wrapping from N-1 to 0.
  - arb_mode=1: the lowest valid index.
- IDLE transitions:
  - Transfer with cmd[EOMBIT]=0 -> LOCKED(owner=i).
  - Transfer with EOM=1 -> stay in IDLE; rr_ptr = (i+1) mod N.
- LOCKED state:
  - sel = onehot(owner) only. Other ports get ready=0 even when the owner's valid is low.
  - Transfer with EOM=1 -> IDLE; rr_ptr = (owner+1) mod N.
  - Transfer with EOM=0 -> stay in LOCKED.
- arb_mode changes take effect only on IDLE decisions and never break a lock.
- Full backpressure: umi_out_ready=0 with out valid -> all readies 0 and the out register holds stable.
- A single active requester streams at one packet per cycle, with no dead cycle between transactions.
- Reset asserted mid-transaction: lock is dropped immediately; out_valid=0.

Optional Feature:
- Macro: UMI_ARB_TIMEOUT_EN. Parameter TIMEOUT (default 255) is present only when it is defined.
- With the macro defined:
  - In LOCKED, an 8-bit counter increments each cycle the owner's valid is 0.
  - The counter clears on any owner transfer.
  - When the count reaches TIMEOUT: return to IDLE, set rr_ptr=(owner+1) mod N, and pulse lock_timeout for 1 cycle.
- Without the macro: no counter exists, a lock is held indefinitely, and lock_timeout is tied to 0.

Decomposition:
- Package umi_arb_pkg: arb_state_e {IDLE, LOCKED}; a function rr_pick(valid, ptr) returning a one-hot value; a localparam for the default TIMEOUT.
- One natural sub-module: umi_arb_rr, a combinational round-robin/fixed-priority picker (valid, ptr, mode -> one-hot sel). It is reused by future response-path muxes.
- The out register and lock FSM stay in the top level.

Test Plan:
- Round-robin fairness: N=4, arb_mode=0, all ports continuously valid with EOM=1, out_ready=1 -> grant_id sequence 0,1,2,3,0,… and one packet per cycle.
- Lock hold: port 2 sends 3 packets with EOM=0,0,1 while port 0 is valid -> out shows 2,2,2 then 0; port 0 ready stays 0 during the lock.
- Fixed priority: arb_mode=1, ports 1 and 3 always valid -> only port 1 is granted; port 3 is starved (expected).
- Backpressure: out_ready toggles 1010 while port 0 streams data 0..7 -> all 8 words are delivered in order, with no loss or duplication.
- Reset mid-lock: assert nreset while locked on port 3 -> out_valid=0 immediately; after release, port 0 wins first.
- Timeout (macro defined, TIMEOUT=4): port 1 sends EOM=0 then drops valid while port 2 is valid -> lock_timeout pulses 4 idle cycles later, then grant_id=2.
